hilo_ctrl: RTL and testbench

HILO_CTRL -- requirements
Module: hilo_ctrl

---
 rtl/hilo_ctrl_pkg.sv | 35 +++
 rtl/hilo_ctrl.sv | 130 +++++++++++++
 tb/tb_hilo_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_ctrl_pkg.sv
// Shared types and constants for the HI/LO register controller that fronts the multiplier.
// Holds the FSM state encoding, data/counter widths and the read-port selection helper.
package hilo_ctrl_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned CNT_W       = 7;
  localparam int unsigned TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Read-port mux: HI wins over LO, and a same-cycle write to the register being read is forwarded.
  function automatic logic [DATA_W-1:0] sel_rdata(
    input logic              rd_hi,
    input logic              rd_lo,
    input logic              fwd_hi,
    input logic              fwd_lo,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] hi,
    input logic [DATA_W-1:0] lo
  );
    logic [DATA_W-1:0] res;
    res = '0;
    if (rd_hi) begin
      res = fwd_hi ? wdata : hi;
    end else if (rd_lo) begin
      res = fwd_lo ? wdata : lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/hilo_ctrl.sv
// HI/LO register file and handshake controller for an external multiplier.
// Issues MULT/MULTU, captures the first result, aborts on timeout, and serves MTHI/MTLO/MFHI/MFLO.
module hilo_ctrl
  import hilo_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              mult_valid_in,
  output logic              mult_sign,
  output logic [DATA_W-1:0] mult_src_a,
  output logic [DATA_W-1:0] mult_src_b,
  input  logic              mult_valid_out,
  input  logic [DATA_W-1:0] mult_hi,
  input  logic [DATA_W-1:0] mult_lo,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mfhi,
  input  logic              mflo,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              busy,
  output logic              timeout_err
);

  state_e            state, state_nxt;
  logic [DATA_W-1:0] hi, hi_nxt;
  logic [DATA_W-1:0] lo, lo_nxt;
  logic [DATA_W-1:0] src_a_nxt, src_b_nxt;
  logic              sign_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
  logic              err_nxt;
  logic              valid_in_nxt;
  logic              busy_nxt;
  logic              req_any;
  logic              wr_ok;
  logic              timeout_hit;

  assign req_any = start | mthi | mtlo | mfhi | mflo;
  assign stall   = (req_any && (state == RUN)) || (start && (state == DRAIN));
  assign wr_ok   = ~stall;

  // Counter reaching TIMEOUT at the end of this RUN cycle means the budget is spent.
  assign cnt_inc     = cnt + CNT_W'(1);
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));

  assign rdata = sel_rdata(mfhi, mflo, mthi & wr_ok, mtlo & wr_ok, wdata, hi, lo);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      hi            <= '0;
      lo            <= '0;
      cnt           <= '0;
      mult_src_a    <= '0;
      mult_src_b    <= '0;
      mult_sign     <= 1'b0;
      timeout_err   <= 1'b0;
      mult_valid_in <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      hi            <= hi_nxt;
      lo            <= lo_nxt;
      cnt           <= cnt_nxt;
      mult_src_a    <= src_a_nxt;
      mult_src_b    <= src_b_nxt;
      mult_sign     <= sign_nxt;
      timeout_err   <= err_nxt;
      mult_valid_in <= valid_in_nxt;
      busy          <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hi_nxt    = hi;
    lo_nxt    = lo;
    cnt_nxt   = cnt;
    src_a_nxt = mult_src_a;
    src_b_nxt = mult_src_b;
    sign_nxt  = mult_sign;
    err_nxt   = timeout_err;

    unique case (state)
      IDLE: begin
        if (mthi && wr_ok) hi_nxt = wdata;
        if (mtlo && wr_ok) lo_nxt = wdata;
        if (start) begin
          src_a_nxt = op_a;
          src_b_nxt = op_b;
          sign_nxt  = is_signed;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        cnt_nxt = cnt_inc;
        // A result arriving on the timeout cycle still counts as success.
        if (mult_valid_out) begin
          hi_nxt    = mult_hi;
          lo_nxt    = mult_lo;
          state_nxt = DRAIN;
        end else if (timeout_hit) begin
          err_nxt   = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (mthi && wr_ok) hi_nxt = wdata;
        if (mtlo && wr_ok) lo_nxt = wdata;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Handshake and status flops track the state being entered so they line up with it.
    valid_in_nxt = (state_nxt == RUN);
    busy_nxt     = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Scoreboard bench for hilo_ctrl: stimulus queues expected reads and multiply outcomes,
// a monitor pops them when the DUT presents an unstalled read or finishes a multiply.
module tb_hilo_ctrl;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a, op_b;
  logic        mult_valid_in;
  logic        mult_sign;
  logic [31:0] mult_src_a, mult_src_b;
  logic        mult_valid_out;
  logic [31:0] mult_hi, mult_lo;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic        mfhi, mflo;
  logic [31:0] rdata;
  logic        stall;
  logic        busy;
  logic        timeout_err;

  hilo_ctrl #(.TIMEOUT(64)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .is_signed      (is_signed),
    .op_a           (op_a),
    .op_b           (op_b),
    .mult_valid_in  (mult_valid_in),
    .mult_sign      (mult_sign),
    .mult_src_a     (mult_src_a),
    .mult_src_b     (mult_src_b),
    .mult_valid_out (mult_valid_out),
    .mult_hi        (mult_hi),
    .mult_lo        (mult_lo),
    .mthi           (mthi),
    .mtlo           (mtlo),
    .wdata          (wdata),
    .mfhi           (mfhi),
    .mflo           (mflo),
    .rdata          (rdata),
    .stall          (stall),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  typedef struct {
    string       name;
    logic [31:0] val;
  } rd_exp_t;

  typedef struct {
    string name;
    int    run;
    int    stall;
    bit    err;
  } mul_exp_t;

  rd_exp_t  rd_q[$];
  mul_exp_t mul_q[$];

  int checks = 0;
  int errors = 0;

  // Multiplier model controls
  int mv_lat      = 3;
  bit mv_noresp   = 1'b0;
  bit mv_spurious = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Multiplier model: answers once after mv_lat RUN cycles, or never when mv_noresp is set.
  initial begin
    int          lat_cnt;
    logic [63:0] p;
    lat_cnt        = 0;
    mult_valid_out = 1'b0;
    mult_hi        = '0;
    mult_lo        = '0;
    forever begin
      @(negedge clk);
      if (reset_n && mult_valid_in && !mv_noresp) begin
        lat_cnt++;
        if (lat_cnt == mv_lat) begin
          if (mult_sign)
            p = $signed({{32{mult_src_a[31]}}, mult_src_a}) * $signed({{32{mult_src_b[31]}}, mult_src_b});
          else
            p = {32'b0, mult_src_a} * {32'b0, mult_src_b};
          mult_hi        = p[63:32];
          mult_lo        = p[31:0];
          mult_valid_out = 1'b1;
        end else begin
          mult_valid_out = 1'b0;
        end
      end else if (reset_n && !mult_valid_in && mv_spurious) begin
        lat_cnt        = 0;
        mult_hi        = 32'hDEADBEEF;
        mult_lo        = 32'hDEADBEEF;
        mult_valid_out = 1'b1;
      end else begin
        lat_cnt        = 0;
        mult_valid_out = 1'b0;
      end
    end
  end

  // Monitor: pops read expectations on unstalled reads, multiply expectations when busy falls.
  initial begin
    int       run_cnt, drain_cnt, stall_cnt;
    bit       prev_busy;
    rd_exp_t  re;
    mul_exp_t me;
    run_cnt = 0; drain_cnt = 0; stall_cnt = 0; prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        run_cnt = 0; drain_cnt = 0; stall_cnt = 0; prev_busy = 1'b0;
      end else begin
        if ((mfhi || mflo) && !stall) begin
          if (rd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_read: rdata 0x%08h with no expectation queued", rdata);
          end else begin
            re = rd_q.pop_front();
            chk(re.name, rdata, re.val);
          end
        end
        if (mult_valid_in) run_cnt++;
        if (busy && !mult_valid_in) drain_cnt++;
        if (busy && stall) stall_cnt++;
        if (prev_busy && !busy) begin
          if (mul_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_multiply: run %0d cycles with no expectation queued", run_cnt);
          end else begin
            me = mul_q.pop_front();
            chk({me.name, "_run_cycles"},   32'(run_cnt),   32'(me.run));
            chk({me.name, "_drain_cycles"}, 32'(drain_cnt), 32'd1);
            chk({me.name, "_stall_cycles"}, 32'(stall_cnt), 32'(me.stall));
            chk({me.name, "_timeout_err"},  32'(timeout_err), 32'(me.err));
          end
          run_cnt = 0; drain_cnt = 0; stall_cnt = 0;
        end
        prev_busy = busy;
      end
    end
  end

  task automatic exp_mul(input string name, input int run, input int stl, input bit err);
    mul_exp_t e;
    e.name = name; e.run = run; e.stall = stl; e.err = err;
    mul_q.push_back(e);
  endtask

  task automatic exp_rd(input string name, input logic [31:0] v);
    rd_exp_t e;
    e.name = name; e.val = v;
    rd_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL %s_idle: still busy after %0d cycles", name, n);
    end
  endtask

  task automatic rd(input bit sel_hi, input string name, input logic [31:0] v);
    exp_rd(name, v);
    if (sel_hi) mfhi = 1'b1; else mflo = 1'b1;
    tick();
    mfhi = 1'b0;
    mflo = 1'b0;
  endtask

  task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                       input bit s, input int lat, input int run, input bit err);
    exp_mul(name, run, 0, err);
    mv_lat = lat;
    op_a = a; op_b = b; is_signed = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(name);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0; mfhi = 1'b0; mflo = 1'b0;
    tick(); tick();
    chk("rst_valid_in", 32'(mult_valid_in), 32'd0);
    chk("rst_busy",     32'(busy),          32'd0);
    chk("rst_stall",    32'(stall),         32'd0);
    chk("rst_err",      32'(timeout_err),   32'd0);
    chk("rst_src_a",    mult_src_a,         32'd0);
    chk("rst_rdata",    rdata,              32'd0);
    reset_n = 1'b1;
    rd(1, "rst_hi", 32'd0);
    rd(0, "rst_lo", 32'd0);

    // Unsigned 7*6
    issue("mulu_7x6", 32'd7, 32'd6, 1'b0, 3, 3, 1'b0);
    rd(1, "mulu_7x6_hi", 32'd0);
    rd(0, "mulu_7x6_lo", 32'd42);

    // Signed -2*3
    issue("mul_neg", 32'hFFFFFFFE, 32'd3, 1'b1, 5, 5, 1'b0);
    rd(1, "mul_neg_hi", 32'hFFFFFFFF);
    rd(0, "mul_neg_lo", 32'hFFFFFFFA);

    // mfhi held through RUN: stalled every RUN cycle, served in DRAIN with the new HI
    exp_mul("mfhi_run", 4, 4, 1'b0);
    exp_rd("mfhi_run_drain_rdata", 32'd3);
    mv_lat = 4; op_a = 32'h0001_0000; op_b = 32'h0003_0000; is_signed = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    mfhi  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall) break;
    end
    @(posedge clk);
    #1;
    mfhi = 1'b0;
    wait_idle("mfhi_run");
    rd(0, "mfhi_run_lo", 32'd0);

    // Minimum latency, full-scale unsigned
    issue("mulu_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1, 1, 1'b0);
    rd(1, "mulu_max_hi", 32'hFFFFFFFE);
    rd(0, "mulu_max_lo", 32'h00000001);

    // Result on the timeout cycle wins
    issue("mul_at_limit", 32'd5, 32'd9, 1'b0, 64, 64, 1'b0);
    rd(1, "mul_at_limit_hi", 32'd0);
    rd(0, "mul_at_limit_lo", 32'd45);

    // Write/read forwarding and priorities in IDLE
    exp_rd("fwd_hi", 32'h12345678);
    wdata = 32'h12345678; mthi = 1'b1; mfhi = 1'b1;
    tick();
    mthi = 1'b0; mfhi = 1'b0;
    rd(1, "mthi_hi", 32'h12345678);
    exp_rd("fwd_lo", 32'hCAFEF00D);
    wdata = 32'hCAFEF00D; mtlo = 1'b1; mflo = 1'b1;
    tick();
    mtlo = 1'b0; mflo = 1'b0;
    rd(0, "mtlo_lo", 32'hCAFEF00D);
    exp_rd("hi_priority", 32'h12345678);
    mfhi = 1'b1; mflo = 1'b1;
    tick();
    mfhi = 1'b0; mflo = 1'b0;
    wdata = 32'hA5A5A5A5; mthi = 1'b1; mtlo = 1'b1;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    rd(1, "both_hi", 32'hA5A5A5A5);
    rd(0, "both_lo", 32'hA5A5A5A5);

    // Stray mult_valid_out outside RUN is ignored
    mv_spurious = 1'b1;
    tick(); tick();
    mv_spurious = 1'b0;
    tick();
    rd(1, "spurious_hi", 32'hA5A5A5A5);
    rd(0, "spurious_lo", 32'hA5A5A5A5);

    // Multiplier never answers
    mv_noresp = 1'b1;
    issue("timeout", 32'd2, 32'd2, 1'b0, 3, 64, 1'b1);
    mv_noresp = 1'b0;
    rd(1, "timeout_hi", 32'hA5A5A5A5);
    rd(0, "timeout_lo", 32'hA5A5A5A5);

    // Write alongside start, later overwritten by the result; error flag stays sticky
    exp_mul("start_wr", 2, 0, 1'b1);
    mv_lat = 2; op_a = 32'd3; op_b = 32'd4; is_signed = 1'b0;
    wdata = 32'h11111111; mthi = 1'b1; mtlo = 1'b1; start = 1'b1;
    tick();
    mthi = 1'b0; mtlo = 1'b0; start = 1'b0;
    wait_idle("start_wr");
    rd(1, "start_wr_hi", 32'd0);
    rd(0, "start_wr_lo", 32'd12);

    // Asynchronous reset mid-RUN
    mv_lat = 10; op_a = 32'd100; op_b = 32'd100; is_signed = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_valid_in", 32'(mult_valid_in), 32'd0);
    chk("midrst_busy",     32'(busy),          32'd0);
    chk("midrst_err",      32'(timeout_err),   32'd0);
    chk("midrst_src_a",    mult_src_a,         32'd0);
    chk("midrst_sign",     32'(mult_sign),     32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rd(1, "midrst_hi", 32'd0);
    rd(0, "midrst_lo", 32'd0);
    issue("after_rst", 32'd8, 32'd8, 1'b0, 2, 2, 1'b0);
    rd(1, "after_rst_hi", 32'd0);
    rd(0, "after_rst_lo", 32'd64);

    tick(); tick();
    chk("rd_queue_drained",  32'(rd_q.size()),  32'd0);
    chk("mul_queue_drained", 32'(mul_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
